// File: rtl/edge_frame_packer_if.sv
// edge_frame_packer_if
//  Packed-byte readout stream from edge_frame_packer toward the plotter host link.
//  Signals (producer = master, consumer = slave):
//   o_rd_valid  master -> slave   packed byte available
//   o_rd_data   master -> slave   packed byte, MSB = leftmost pixel
//   o_rd_last   master -> slave   high with the final byte of the frame
//   i_rd_ready  slave  -> master  byte accepted when o_rd_valid && i_rd_ready
interface edge_frame_packer_if;
    logic       o_rd_valid;
    logic [7:0] o_rd_data;
    logic       o_rd_last;
    logic       i_rd_ready;

    modport master (output o_rd_valid, output o_rd_data, output o_rd_last, input i_rd_ready);
    modport slave  (input o_rd_valid, input o_rd_data, input o_rd_last, output i_rd_ready);
endinterface

// File: rtl/edge_frame_packer.sv
// edge_frame_packer
//  Captures one armed frame of the binary Canny edge stream into an internal RAM,
//  packed 1 bit/pixel (MSB = leftmost pixel), then streams the packed bytes out over a
//  valid/ready byte interface. One capture per i_start; RAM is stable during readout.
// Ports:
//  clk, rstn     clock (posedge) and asynchronous active-low reset
//  i_vsync       frame sync, rising edge starts a frame / ends a short frame
//  i_hsync       line sync (informational only)
//  i_de          pixel valid, falling edge ends a line
//  i_data        edge pixel, bit = (i_data >= EDGE_TH)
//  i_start       arm capture of the next frame (accepted only when idle)
//  o_busy        high while armed, capturing or reading out
//  o_done        one-cycle pulse after the final byte handshake
//  o_frame_err   sticky line-length / early-vsync error, cleared on accepted i_start
//  rd            packed byte stream (edge_frame_packer_if.master)
module edge_frame_packer #(
    parameter int WIDTH   = 8,
    parameter int H_RES   = 170,
    parameter int V_RES   = 240,
    parameter int EDGE_TH = 128
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_vsync,
    input  logic                       i_hsync,
    input  logic                       i_de,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_start,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_frame_err,
    edge_frame_packer_if.master        rd
);
    localparam int BPL = (H_RES + 7) / 8;     // bytes per line
    localparam int N   = V_RES * BPL;         // bytes per frame
    localparam int CW  = $clog2(H_RES + 1);
    localparam int LW  = $clog2(V_RES + 1);
    localparam int AW  = $clog2(N + 1);
    localparam int BW  = $clog2(BPL + 1);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} state_t;

    state_t state_q, state_d;

    // Line sync carries no information the column counter does not already have.
    logic unused_hsync;
    assign unused_hsync = i_hsync;

    // ------------------------------------------------------------------ input edges
    logic vsync_q, de_q, vs_rise, de_fall;

    // NOTE: clocked state is always assigned with <= so every register samples the
    // pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vsync_q <= 1'b0;
            de_q    <= 1'b0;
        end else begin
            vsync_q <= i_vsync;
            de_q    <= i_de;
        end
    end

    assign vs_rise = i_vsync & ~vsync_q;
    assign de_fall = de_q & ~i_de;

    // ------------------------------------------------------------------ capture
    logic [CW-1:0] col_q;
    logic [LW-1:0] line_q;
    logic [AW-1:0] line_base_q;
    logic [7:0]    cur_byte_q;
    logic          err_q;

    logic          start_acc, in_capture, pix_bit, pix_take, pix_drop;
    logic          line_end, last_line, early_vs;
    logic [2:0]    bit_pos;
    logic [7:0]    pix_byte;
    logic [BW-1:0] line_bytes;

    assign start_acc  = (state_q == IDLE) && i_start;
    assign in_capture = (state_q == CAPTURE);
    assign pix_bit    = (i_data >= WIDTH'(EDGE_TH));
    assign pix_take   = in_capture && i_de && (col_q < CW'(H_RES));
    assign pix_drop   = in_capture && i_de && (col_q == CW'(H_RES));
    // A line with no accepted pixels is not a line at all.
    assign line_end   = in_capture && de_fall && (col_q != '0);
    assign last_line  = line_end && (line_q == LW'(V_RES - 1));
    // A vsync coinciding with the final line end is the normal frame end, not early.
    assign early_vs   = in_capture && vs_rise && !last_line;

    // Byte under construction with the new pixel dropped into its bit; the first pixel
    // of a byte starts from zero so a partial byte is zero-padded in its LSBs.
    assign bit_pos    = 3'd7 - col_q[2:0];
    assign pix_byte   = ((col_q[2:0] == 3'd0) ? 8'h00 : cur_byte_q) | (8'(pix_bit) << bit_pos);
    assign line_bytes = BW'(col_q[CW-1:3]) + BW'(|col_q[2:0]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q       <= '0;
            line_q      <= '0;
            line_base_q <= '0;
            cur_byte_q  <= '0;
            err_q       <= 1'b0;
        end else if (start_acc) begin
            col_q       <= '0;
            line_q      <= '0;
            line_base_q <= '0;
            cur_byte_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            if (pix_take) begin
                cur_byte_q <= pix_byte;
                col_q      <= col_q + CW'(1);
            end
            if (line_end) begin
                col_q       <= '0;
                line_q      <= line_q + LW'(1);
                line_base_q <= line_base_q + AW'(BPL);
            end
            if (pix_drop || early_vs || (line_end && (col_q != CW'(H_RES))))
                err_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------ RAM write
    logic          wr_en;
    logic [7:0]    wr_data;
    logic [AW-1:0] wr_addr;

    assign wr_addr = line_base_q + AW'(col_q[CW-1:3]);

    // NOTE: every signal driven in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = pix_byte;
        if (pix_take && (col_q[2:0] == 3'd7)) begin
            wr_en = 1'b1;
        end else if (line_end && (col_q[2:0] != 3'd0)) begin
            wr_en   = 1'b1;
            wr_data = cur_byte_q;
        end
    end

    // ------------------------------------------------------------------ storage
    // Short lines record how many bytes they actually wrote; readout masks the rest
    // to 0x00, which avoids a fill engine racing the next line.
    logic [7:0]    ram [N];
    logic [BW-1:0] len_tab [V_RES];
    logic [7:0]    ram_q;
    logic [AW-1:0] rd_addr_q;

    // NOTE: the frame RAM, length table and RAM output register have no reset;
    // their contents are only ever read after being written for the current frame.
    always_ff @(posedge clk) begin
        if (wr_en)
            ram[wr_addr] <= wr_data;
        if (line_end)
            len_tab[line_q[LW-1:0]] <= line_bytes;
        ram_q <= ram[rd_addr_q];
    end

    // ------------------------------------------------------------------ readout
    // Reads are issued into a 2-entry FIFO with credit accounting for the one read
    // in flight, giving 1 byte/cycle with a registered RAM and a stable head on stall.
    logic [LW-1:0] rd_line_q;
    logic [BW-1:0] rd_byte_q;
    logic          rd_all_q, inflight_q, zero_q, last_q;
    logic [7:0]    fq_data [2];
    logic          fq_last [2];
    logic          fq_rp, fq_wp;
    logic [1:0]    fq_cnt;
    logic          pop, final_pop, issue;
    logic [2:0]    occ;

    assign rd.o_rd_valid = (fq_cnt != 2'd0);
    assign rd.o_rd_data  = fq_data[fq_rp];
    assign rd.o_rd_last  = fq_last[fq_rp];

    assign pop       = rd.o_rd_valid && rd.i_rd_ready;
    assign final_pop = pop && fq_last[fq_rp];
    assign occ       = 3'(fq_cnt) + 3'(inflight_q) - 3'(pop);
    assign issue     = (state_q == READOUT) && !rd_all_q && (occ < 3'd2);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_addr_q  <= '0;
            rd_line_q  <= '0;
            rd_byte_q  <= '0;
            rd_all_q   <= 1'b0;
            inflight_q <= 1'b0;
            zero_q     <= 1'b0;
            last_q     <= 1'b0;
            fq_data[0] <= '0;
            fq_data[1] <= '0;
            fq_last[0] <= 1'b0;
            fq_last[1] <= 1'b0;
            fq_rp      <= 1'b0;
            fq_wp      <= 1'b0;
            fq_cnt     <= '0;
        end else if (start_acc) begin
            rd_addr_q  <= '0;
            rd_line_q  <= '0;
            rd_byte_q  <= '0;
            rd_all_q   <= 1'b0;
            inflight_q <= 1'b0;
            fq_rp      <= 1'b0;
            fq_wp      <= 1'b0;
            fq_cnt     <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                // Lines never captured, or bytes past a short line's end, read as 0x00.
                zero_q <= (rd_line_q >= line_q) || (rd_byte_q >= len_tab[rd_line_q]);
                last_q <= (rd_addr_q == AW'(N - 1));
                if (rd_addr_q == AW'(N - 1)) begin
                    rd_all_q <= 1'b1;
                end else begin
                    rd_addr_q <= rd_addr_q + AW'(1);
                    if (rd_byte_q == BW'(BPL - 1)) begin
                        rd_byte_q <= '0;
                        rd_line_q <= rd_line_q + LW'(1);
                    end else begin
                        rd_byte_q <= rd_byte_q + BW'(1);
                    end
                end
            end
            if (inflight_q) begin
                fq_data[fq_wp] <= zero_q ? 8'h00 : ram_q;
                fq_last[fq_wp] <= last_q;
                fq_wp          <= ~fq_wp;
            end
            if (pop)
                fq_rp <= ~fq_rp;
            fq_cnt <= fq_cnt + 2'(inflight_q) - 2'(pop);
        end
    end

    // ------------------------------------------------------------------ FSM
    logic done_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == READOUT) && final_pop;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_start)                state_d = ARMED;
            ARMED:   if (vs_rise)                state_d = CAPTURE;
            CAPTURE: if (last_line || vs_rise)   state_d = READOUT;
            READOUT: if (final_pop)              state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    assign o_busy      = (state_q != IDLE);
    assign o_done      = done_q;
    assign o_frame_err = err_q;
endmodule

// File: tb/tb_edge_frame_packer.sv
`timescale 1ns/1ps
module tb_edge_frame_packer;
    // Reduced frame height; line width kept at 170 so the 2-pixel tail byte still appears.
    localparam int H_RES = 170;
    localparam int V_RES = 12;
    localparam int TH    = 128;
    localparam int BPL   = (H_RES + 7) / 8;
    localparam int N     = V_RES * BPL;
    localparam int MAXC  = H_RES + 16;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rstn  = 1'b0;
    logic       vsync = 1'b0;
    logic       hsync = 1'b0;
    logic       de    = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       busy, done, frame_err;

    edge_frame_packer_if rd_if ();

    edge_frame_packer #(
        .WIDTH(8), .H_RES(H_RES), .V_RES(V_RES), .EDGE_TH(TH)
    ) dut (
        .clk(clk), .rstn(rstn), .i_vsync(vsync), .i_hsync(hsync), .i_de(de),
        .i_data(data), .i_start(start), .o_busy(busy), .o_done(done),
        .o_frame_err(frame_err), .rd(rd_if)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    exp_t       exp_q[$];
    int         rx_cnt = 0;
    int         done_cnt = 0;
    bit         rand_ready = 1'b0;
    bit         stall_hold = 1'b0;
    logic [7:0] held_data;
    logic       held_last;
    logic [7:0] px [V_RES][MAXC];
    int         line_len [V_RES];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Consumer back-pressure.
    always @(posedge clk) begin
        #1;
        rd_if.i_rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: scoreboard compare on every handshake, stall stability, done pulses.
    always @(negedge clk) begin
        if (!rstn) begin
            stall_hold = 1'b0;
        end else begin
            if (stall_hold)
                check("stall_stable", 32'({rd_if.o_rd_valid, rd_if.o_rd_last, rd_if.o_rd_data}),
                      32'({1'b1, held_last, held_data}));
            if (rd_if.o_rd_valid && rd_if.i_rd_ready) begin
                check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rd_byte", 32'({rd_if.o_rd_last, rd_if.o_rd_data}), 32'(e));
                end
                rx_cnt++;
            end
            stall_hold = rd_if.o_rd_valid && !rd_if.i_rd_ready;
            held_data  = rd_if.o_rd_data;
            held_last  = rd_if.o_rd_last;
            if (done)
                done_cnt++;
        end
    end

    task automatic set_full_lines();
        for (int l = 0; l < V_RES; l++)
            line_len[l] = H_RES;
    endtask

    // Reference model: pixels per line, then expected bytes straight from the packing rules.
    task automatic prepare_frame(input int mode, input int n_lines, output bit exp_err);
        exp_err = (n_lines < V_RES);
        for (int l = 0; l < V_RES; l++)
            for (int c = 0; c < MAXC; c++)
                case (mode)
                    0:       px[l][c] = 8'hFF;
                    1:       px[l][c] = (c % 2 == 0) ? 8'hFF : 8'h00;
                    default: px[l][c] = ($urandom_range(0, 3) == 0)
                                        ? 8'(127 + $urandom_range(0, 1)) : 8'($urandom);
                endcase
        for (int l = 0; l < n_lines; l++)
            if (line_len[l] != H_RES)
                exp_err = 1'b1;
        for (int a = 0; a < N; a++) begin
            automatic int   l  = a / BPL;
            automatic int   b  = a % BPL;
            automatic logic [7:0] b8 = 8'h00;
            exp_t e;
            if (l < n_lines)
                for (int i = 0; i < 8; i++) begin
                    automatic int k = b * 8 + i;
                    if (k < line_len[l] && k < H_RES && px[l][k] >= 8'(TH))
                        b8 = b8 | (8'h80 >> i);
                end
            e.last = (a == N - 1);
            e.data = b8;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_frame(input int n_lines, input bit poke);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("busy_armed", 32'(busy), 32'd1);
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (4) tick();
        for (int l = 0; l < n_lines; l++) begin
            hsync = 1'b1;
            tick();
            hsync = 1'b0;
            for (int c = 0; c < line_len[l]; c++) begin
                de    = 1'b1;
                data  = px[l][c];
                start = 1'(poke && l == 2 && c == 10);
                tick();
            end
            de    = 1'b0;
            start = 1'b0;
            data  = 8'h00;
            repeat (4) tick();
        end
        if (n_lines < V_RES) begin
            vsync = 1'b1;
            repeat (3) tick();
            vsync = 1'b0;
        end
        if (poke) begin
            repeat (6) tick();
            check("busy_in_readout", 32'(busy), 32'd1);
            start = 1'b1;
            tick();
            start = 1'b0;
        end
    endtask

    task automatic finish_frame(input bit exp_err);
        for (int i = 0; i < 20000 && done_cnt == 0; i++)
            tick();
        repeat (3) tick();
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("bytes_rx", 32'(rx_cnt), 32'(N));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("frame_err", 32'(frame_err), 32'(exp_err));
        check("busy_idle", 32'(busy), 32'd0);
        exp_q.delete();
        done_cnt = 0;
        rx_cnt   = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit e;
        rd_if.i_rd_ready = 1'b1;
        repeat (3) tick();
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(frame_err), 32'd0);
        check("rst_valid", 32'(rd_if.o_rd_valid), 32'd0);
        check("rst_last",  32'(rd_if.o_rd_last), 32'd0);
        check("rst_data",  32'(rd_if.o_rd_data), 32'd0);
        rstn = 1'b1;
        tick();

        // All-edge frame, always ready.
        set_full_lines();
        rand_ready = 1'b0;
        prepare_frame(0, V_RES, e); drive_frame(V_RES, 1'b0); finish_frame(e);

        // Alternating pixels.
        prepare_frame(1, V_RES, e); drive_frame(V_RES, 1'b0); finish_frame(e);

        // All-edge frame under random back-pressure.
        rand_ready = 1'b1;
        prepare_frame(0, V_RES, e); drive_frame(V_RES, 1'b0); finish_frame(e);

        // Short line 5.
        line_len[5] = 160;
        prepare_frame(2, V_RES, e); drive_frame(V_RES, 1'b0); finish_frame(e);

        // Over-long and odd-short lines.
        set_full_lines();
        line_len[3] = 175;
        line_len[7] = 169;
        prepare_frame(2, V_RES, e); drive_frame(V_RES, 1'b0); finish_frame(e);

        // Early vsync after 5 lines.
        set_full_lines();
        prepare_frame(2, 5, e); drive_frame(5, 1'b0); finish_frame(e);

        // i_start during capture and readout has no effect.
        rand_ready = 1'b0;
        prepare_frame(2, V_RES, e); drive_frame(V_RES, 1'b1); finish_frame(e);

        // Reset in the middle of readout of an errored frame.
        line_len[4] = 175;
        prepare_frame(2, V_RES, e); drive_frame(V_RES, 1'b0);
        repeat (40) tick();
        check("valid_mid_readout", 32'(rd_if.o_rd_valid), 32'd1);
        rstn = 1'b0;
        #1;
        check("abort_valid", 32'(rd_if.o_rd_valid), 32'd0);
        check("abort_busy",  32'(busy), 32'd0);
        check("abort_err",   32'(frame_err), 32'd0);
        exp_q.delete();
        tick();
        tick();
        rstn = 1'b1;
        rx_cnt   = 0;
        done_cnt = 0;
        tick();

        // Normal capture after the abort.
        set_full_lines();
        rand_ready = 1'b1;
        prepare_frame(2, V_RES, e); drive_frame(V_RES, 1'b0); finish_frame(e);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
